// File: rtl/mux16_rr_scheduler_pkg.sv
// mux16_rr_scheduler_pkg: shared sizes, FSM state encoding and round-robin pick function
package mux16_rr_scheduler_pkg;
  localparam int N = 16;
  localparam int SEL_W = 4;

  typedef enum logic [1:0] {IDLE = 2'b00, SELECT = 2'b01, HOLD = 2'b10} state_t;

  // First set request at or after ptr, wrapping through natural 4-bit overflow
  function automatic logic [SEL_W-1:0] rr_pick(input logic [N-1:0] req, input logic [SEL_W-1:0] ptr);
    logic [SEL_W-1:0] idx;
    logic found;
    rr_pick = ptr;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = ptr + SEL_W'(k);
      if (!found && req[idx]) begin
        rr_pick = idx;
        found = 1'b1;
      end
    end
  endfunction
endpackage

// File: rtl/mux16_rr_scheduler_mux.sv
// mux16_rr_scheduler_mux: 16:1 single-bit mux built as a tree of 2:1 stages
module mux16_rr_scheduler_mux (
  input  logic [15:0] d_i,
  input  logic [3:0]  s_i,
  output logic        y_o
);
  logic [7:0] l1;
  logic [3:0] l2;
  logic [1:0] l3;
  for (genvar i = 0; i < 8; i++) assign l1[i] = s_i[0] ? d_i[2*i+1] : d_i[2*i];
  for (genvar i = 0; i < 4; i++) assign l2[i] = s_i[1] ? l1[2*i+1] : l1[2*i];
  for (genvar i = 0; i < 2; i++) assign l3[i] = s_i[2] ? l2[2*i+1] : l2[2*i];
  assign y_o = s_i[3] ? l3[1] : l3[0];
endmodule

// File: rtl/mux16_rr_scheduler.sv
// mux16_rr_scheduler: round-robin arbiter sharing one 16:1 mux, output on a valid/ready handshake
module mux16_rr_scheduler
  import mux16_rr_scheduler_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req_i,
  input  logic [N-1:0]     din_i,
  input  logic             out_ready_i,
  output logic [SEL_W-1:0] sel_o,
  output logic [N-1:0]     grant_o,
  output logic             out_data_o,
  output logic             out_valid_o,
  output logic [N-1:0]     ack_o,
  output logic             busy_o
);
  state_t           state_q;
  logic [SEL_W-1:0] sel_q, ptr_q, pick_d;
  logic [N-1:0]     grant_q, ack_q;
  logic             out_data_q, out_valid_q, mux_y;

  assign pick_d = rr_pick(req_i, ptr_q);

  mux16_rr_scheduler_mux u_mux (
    .d_i(din_i),
    .s_i(sel_q),
    .y_o(mux_y)
  );

  // Unused encoding 2'b11 falls into the default arm and behaves as IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sel_q       <= '0;
      ptr_q       <= '0;
      grant_q     <= '0;
      ack_q       <= '0;
      out_data_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      ack_q <= '0;
      case (state_q)
        SELECT: begin
          out_data_q  <= mux_y;
          out_valid_q <= 1'b1;
          state_q     <= HOLD;
        end
        HOLD: if (out_ready_i) begin
          out_valid_q <= 1'b0;
          grant_q     <= '0;
          ack_q       <= grant_q;
          ptr_q       <= sel_q + 1'b1;
          state_q     <= IDLE;
        end
        default: if (|req_i) begin
          sel_q   <= pick_d;
          grant_q <= N'(1) << pick_d;
          state_q <= SELECT;
        end
      endcase
    end
  end

  assign sel_o       = sel_q;
  assign grant_o     = grant_q;
  assign ack_o       = ack_q;
  assign out_data_o  = out_data_q;
  assign out_valid_o = out_valid_q;
  assign busy_o      = (state_q == SELECT) || (state_q == HOLD);
endmodule

// File: doc/mux16_rr_scheduler.md
# mux16_rr_scheduler

Round-robin scheduler that shares a single 16:1 single-bit mux between 16 requesters. It arbitrates among pending requests and drives the mux select from a register. It then captures the selected bit into an output register and presents it on a valid/ready handshake, acknowledging the winner once the transfer completes. It sits between the requesting lanes and the downstream consumer, and owns the mux instance.

## Interface
- `N`, default 16: number of requesters; fixed at 16 to match the mux width.
- `SEL_W`, default 4: select width, log2(N).

- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous active-low reset
- `req`  in  16  per-requester request; must hold until the matching `ack` bit
- `din`  in  16  per-requester data bit, routed through the mux
- `sel`  out  4  registered mux select, equal to the current grant index
- `grant`  out  16  one-hot registered grant; zero when idle
- `out_data`  out  1  captured mux output
- `out_valid`  out  1  `out_data` is valid
- `out_ready`  in  1  consumer accepts `out_data`
- `ack`  out  16  one-hot, one-cycle pulse to the served requester
- `busy`  out  1  FSM not in IDLE

## Operation
- FSM states:
  - IDLE: when `req` is nonzero, pick a winner (see below), load `sel` and `grant`, go to SELECT.
  - SELECT: one settle cycle. Capture the mux output into `out_data`, set `out_valid`, go to HOLD.
  - HOLD: hold `out_data`, `out_valid`, `sel` and `grant` stable. On `out_valid && out_ready`:
    - clear `out_valid` and `grant`;
    - pulse `ack[sel]`;
    - set `ptr = (sel + 1) mod 16`;
    - go to IDLE.
- Winner selection: the lowest index `i` with `req[i]` set, searching from `ptr` upward and wrapping 15→0. `ptr` resets to 0.
- The winner is never re-granted back-to-back while any other request is pending. If it is the only requester, it is re-granted after the IDLE cycle.
- If `req[sel]` drops during SELECT or HOLD (protocol violation), the transfer still completes and `ack` still pulses. No abort.
- `din` is sampled only in SELECT. Changes to `din` in HOLD do not affect `out_data`.
- Index arithmetic is modulo 16 over 4 bits; wrap is natural overflow.
- Reset (asynchronous, any state):
  - outputs: `sel`=0, `grant`=0, `out_data`=0, `out_valid`=0, `ack`=0, `busy`=0;
  - internal: `ptr`=0, state IDLE.
  - An in-flight transfer is dropped with no `ack`.

## Timing
- Request sampled at edge T in IDLE:
  - `sel`/`grant` valid after T;
  - `out_valid` high after T+1.
- Minimum latency from request to `out_valid` is 2 cycles.
- Handshake completes at edge H. `ack` is high for exactly the cycle after H, during which the FSM is in IDLE.
- The earliest next grant is loaded at edge H+1.
- Best-case throughput is one transfer per 3 cycles when `out_ready` is held high.
- `out_valid` never drops without a handshake, except on reset.
- `out_ready` has no effect while `out_valid` is low.
- `sel` changes only on the IDLE→SELECT transition, so the mux input is stable for the whole SELECT and HOLD window.
- `ack` and `grant` are never high in the same cycle.

## Structure
- Shared package holds:
  - `N` = 16 and `SEL_W` = 4;
  - the state enum `{IDLE, SELECT, HOLD}`, 2-bit encoding 00/01/10 (11 is illegal and decodes to IDLE);
  - `rr_pick(req, ptr)`, a function returning the 4-bit winner index.
- One sub-module: the team's existing 16:1 gate-level mux, instantiated as `u_mux`. Its inputs are `din` and the registered `sel`; its output feeds the `out_data` capture register.
- The remaining logic is FSM, pointer and output registers in the top module.

## Test plan
- Single request: `req`=0x0010, `din[4]`=1, `out_ready`=1.
  - `sel`=4 after 1 cycle; `out_valid`=1, `out_data`=1 after 2 cycles.
  - `ack`=0x0010 for one cycle after the handshake; `ptr`=5.
- Round-robin fairness: `req`=0xFFFF held, with each requester deasserting on its `ack`, `out_ready`=1. Grants run 0,1,…,15 in order, each index exactly once.
- Wrap-around: `ptr`=14, `req`=0x0009. Grant order is 0 then 3; 14 and 15 are skipped.
- Backpressure: `out_ready`=0 for 10 cycles, with `din` toggling during HOLD.
  - `out_valid`, `out_data`, `sel` and `grant` stay stable, and there is no `ack`.
  - After `out_ready`=1, a single `ack` pulse.
- Reset mid-transfer: assert `rst_n`=0 asynchronously in HOLD.
  - All outputs go to 0 immediately, with no `ack`.
  - After release with `req`=0x8001, the first grant is index 0.
- Dropped request: `req[7]` deasserts during SELECT. The transfer still completes and `ack[7]` pulses.
